// File: rtl/ysyx_22040237_mcyc_ctrl_pkg.sv
// Shared definitions for the ysyx_22040237 multi-cycle sequencer:
// state encoding, reset instruction and default bus widths.
package ysyx_22040237_mcyc_ctrl_pkg;

  localparam int unsigned ADDR_W_DEF = 64;
  localparam int unsigned DATA_W_DEF = 64;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_FETCH_REQ  = 3'd1,
    S_FETCH_WAIT = 3'd2,
    S_EXEC       = 3'd3,
    S_MEM_REQ    = 3'd4,
    S_MEM_WAIT   = 3'd5,
    S_WB         = 3'd6,
    S_HALT       = 3'd7
  } state_e;

endpackage

// File: rtl/ysyx_22040237_mcyc_ctrl_perf_cnt.sv
// Cycle and retired-instruction counters for the multi-cycle sequencer.
// Only instantiated when YSYX_22040237_PERF_CNT_EN is defined.
module ysyx_22040237_perf_cnt (
  input  logic        clk,
  input  logic        rst,
  input  logic        cycle_en_i,
  input  logic        retire_i,
  output logic [63:0] cycle_cnt_o,
  output logic [63:0] instret_o
);

  logic [63:0] cycle_q, cycle_d;
  logic [63:0] instret_q, instret_d;

  // Increment enables come straight from the sequencer state.
  always_comb begin
    cycle_d   = cycle_q;
    instret_d = instret_q;
    if (cycle_en_i) cycle_d   = cycle_q + 64'd1;
    if (retire_i)   instret_d = instret_q + 64'd1;
  end

  // Counter registers, cleared by synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_q   <= '0;
      instret_q <= '0;
    end else begin
      cycle_q   <= cycle_d;
      instret_q <= instret_d;
    end
  end

  assign cycle_cnt_o = cycle_q;
  assign instret_o   = instret_q;

endmodule

// File: rtl/ysyx_22040237_mcyc_ctrl.sv
// Multi-cycle instruction sequencer and shared memory port arbiter.
// Steps FETCH -> EXEC -> (MEM) -> WB, muxes the memory port between
// instruction fetch and LSU, and strobes PC update / regfile write.
// Optional: YSYX_22040237_PERF_CNT_EN adds cycle_cnt_o / instret_o.
module ysyx_22040237_mcyc_ctrl
  import ysyx_22040237_mcyc_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_i,
  output logic              pc_we_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic [7:0]        mem_wmask_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic [31:0]       inst_o,
  input  logic              dec_is_load_i,
  input  logic              dec_is_store_i,
  input  logic              dec_invalid_i,
  input  logic              dec_halt_i,
  input  logic              rd_wr_en_i,
  input  logic [ADDR_W-1:0] lsu_addr_i,
  input  logic [DATA_W-1:0] lsu_wdata_i,
  input  logic [7:0]        lsu_wmask_i,
  output logic [DATA_W-1:0] lsu_rdata_o,
  output logic              rf_we_o,
  output logic              halted_o,
`ifdef YSYX_22040237_PERF_CNT_EN
  output logic [63:0]       cycle_cnt_o,
  output logic [63:0]       instret_o,
`endif
  output logic              trap_o
);

  state_e            state_q, state_d;
  logic [31:0]       inst_q, inst_d;
  logic [DATA_W-1:0] lsu_rdata_q, lsu_rdata_d;
  logic              trap_q, trap_d;

  // Next-state logic and capture of fetched instruction / load data.
  always_comb begin
    state_d     = state_q;
    inst_d      = inst_q;
    lsu_rdata_d = lsu_rdata_q;
    trap_d      = trap_q;
    unique case (state_q)
      S_IDLE:       state_d = S_FETCH_REQ;
      S_FETCH_REQ:  if (mem_gnt_i) state_d = S_FETCH_WAIT;
      S_FETCH_WAIT: begin
        if (mem_rvalid_i) begin
          inst_d  = pc_i[2] ? mem_rdata_i[63:32] : mem_rdata_i[31:0];
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (dec_invalid_i) begin
          trap_d  = 1'b1;
          state_d = S_HALT;
        end else if (dec_halt_i) begin
          state_d = S_HALT;
        end else if (dec_is_load_i || dec_is_store_i) begin
          state_d = S_MEM_REQ;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM_REQ:    if (mem_gnt_i) state_d = S_MEM_WAIT;
      S_MEM_WAIT: begin
        if (mem_rvalid_i) begin
          if (dec_is_load_i) lsu_rdata_d = mem_rdata_i;
          state_d = S_WB;
        end
      end
      S_WB:         state_d = S_FETCH_REQ;
      S_HALT:       state_d = S_HALT;
      default:      state_d = S_IDLE;
    endcase
  end

  // State and datapath capture registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      inst_q      <= NOP_INST;
      lsu_rdata_q <= '0;
      trap_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      inst_q      <= inst_d;
      lsu_rdata_q <= lsu_rdata_d;
      trap_q      <= trap_d;
    end
  end

  // Moore outputs: request fields are held stable while in a REQ state.
  always_comb begin
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_wmask_o = '0;
    pc_we_o     = 1'b0;
    rf_we_o     = 1'b0;
    unique case (state_q)
      S_FETCH_REQ: begin
        mem_req_o  = 1'b1;
        mem_addr_o = pc_i;
      end
      S_MEM_REQ: begin
        mem_req_o  = 1'b1;
        mem_we_o   = dec_is_store_i;
        mem_addr_o = lsu_addr_i;
        if (dec_is_store_i) begin
          mem_wdata_o = lsu_wdata_i;
          mem_wmask_o = lsu_wmask_i;
        end
      end
      S_WB: begin
        pc_we_o = 1'b1;
        rf_we_o = rd_wr_en_i;
      end
      default: ;
    endcase
  end

  assign inst_o      = inst_q;
  assign lsu_rdata_o = lsu_rdata_q;
  assign halted_o    = (state_q == S_HALT);
  assign trap_o      = trap_q;

`ifdef YSYX_22040237_PERF_CNT_EN
  ysyx_22040237_perf_cnt u_perf_cnt (
    .clk         (clk),
    .rst         (rst),
    .cycle_en_i  (state_q != S_HALT),
    .retire_i    (state_q == S_WB),
    .cycle_cnt_o (cycle_cnt_o),
    .instret_o   (instret_o)
  );
`endif

endmodule

// File: tb/tb_ysyx_22040237_mcyc_ctrl.sv
// Directed self-checking bench for ysyx_22040237_mcyc_ctrl.
module tb_ysyx_22040237_mcyc_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] pc_i;
  logic        pc_we_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [63:0] mem_addr_o;
  logic [63:0] mem_wdata_o;
  logic [7:0]  mem_wmask_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [63:0] mem_rdata_i;
  logic [31:0] inst_o;
  logic        dec_is_load_i, dec_is_store_i, dec_invalid_i, dec_halt_i;
  logic        rd_wr_en_i;
  logic [63:0] lsu_addr_i;
  logic [63:0] lsu_wdata_i;
  logic [7:0]  lsu_wmask_i;
  logic [63:0] lsu_rdata_o;
  logic        rf_we_o;
  logic        halted_o;
  logic        trap_o;
`ifdef YSYX_22040237_PERF_CNT_EN
  logic [63:0] cycle_cnt_o;
  logic [63:0] instret_o;
`endif

  int unsigned checks = 0;
  int unsigned errors = 0;

  ysyx_22040237_mcyc_ctrl #(.ADDR_W(64), .DATA_W(64)) dut (
    .clk            (clk),
    .rst            (rst),
    .pc_i           (pc_i),
    .pc_we_o        (pc_we_o),
    .mem_req_o      (mem_req_o),
    .mem_we_o       (mem_we_o),
    .mem_addr_o     (mem_addr_o),
    .mem_wdata_o    (mem_wdata_o),
    .mem_wmask_o    (mem_wmask_o),
    .mem_gnt_i      (mem_gnt_i),
    .mem_rvalid_i   (mem_rvalid_i),
    .mem_rdata_i    (mem_rdata_i),
    .inst_o         (inst_o),
    .dec_is_load_i  (dec_is_load_i),
    .dec_is_store_i (dec_is_store_i),
    .dec_invalid_i  (dec_invalid_i),
    .dec_halt_i     (dec_halt_i),
    .rd_wr_en_i     (rd_wr_en_i),
    .lsu_addr_i     (lsu_addr_i),
    .lsu_wdata_i    (lsu_wdata_i),
    .lsu_wmask_i    (lsu_wmask_i),
    .lsu_rdata_o    (lsu_rdata_o),
    .rf_we_o        (rf_we_o),
    .halted_o       (halted_o),
`ifdef YSYX_22040237_PERF_CNT_EN
    .cycle_cnt_o    (cycle_cnt_o),
    .instret_o      (instret_o),
`endif
    .trap_o         (trap_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"},    {63'd0, mem_req_o}, 64'd0);
    check({tag, "_pcwe"},   {63'd0, pc_we_o},   64'd0);
    check({tag, "_rfwe"},   {63'd0, rf_we_o},   64'd0);
    check({tag, "_halted"}, {63'd0, halted_o},  64'd0);
    check({tag, "_trap"},   {63'd0, trap_o},    64'd0);
    check({tag, "_inst"},   {32'd0, inst_o},    64'h13);
    check({tag, "_ldata"},  lsu_rdata_o,        64'd0);
  endtask

  // Called while in FETCH_REQ with pc_i already set; returns in EXEC.
  task automatic do_fetch(input logic [63:0] pc, input logic [63:0] rdata,
                          input int unsigned gwait, input int unsigned rwait,
                          input logic [31:0] exp_inst);
    for (int unsigned i = 0; i < gwait; i++) begin
      check("freq_stall_req",  {63'd0, mem_req_o}, 64'd1);
      check("freq_stall_addr", mem_addr_o, pc);
      tick();
    end
    mem_gnt_i = 1'b1;
    check("freq_req",  {63'd0, mem_req_o}, 64'd1);
    check("freq_we",   {63'd0, mem_we_o},  64'd0);
    check("freq_addr", mem_addr_o, pc);
    check("freq_mask", {56'd0, mem_wmask_o}, 64'd0);
    tick();
    mem_gnt_i = 1'b0;
    for (int unsigned i = 0; i < rwait; i++) begin
      check("fwait_noreq", {63'd0, mem_req_o}, 64'd0);
      tick();
    end
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = rdata;
    tick();
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = 64'h5555_5555_5555_5555;
    check("exec_inst", {32'd0, inst_o}, {32'd0, exp_inst});
  endtask

  initial begin
    rst = 1'b1;
    pc_i = 64'h8000_0000;
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
    dec_is_load_i = 1'b0; dec_is_store_i = 1'b0;
    dec_invalid_i = 1'b0; dec_halt_i = 1'b0; rd_wr_en_i = 1'b0;
    lsu_addr_i = '0; lsu_wdata_i = '0; lsu_wmask_i = '0;

    tick(); tick();
    check_reset_outputs("rst");

    // 1: addi at 0x80000000, zero-wait memory; WB is the 4th cycle after IDLE.
    rst = 1'b0;
    rd_wr_en_i = 1'b1;
    tick();                                   // cycle 1: FETCH_REQ
    do_fetch(64'h8000_0000, 64'h0000_0000_0010_0093, 0, 0, 32'h0010_0093); // cycle 3: EXEC
    check("addi_exec_pcwe", {63'd0, pc_we_o}, 64'd0);
    tick();                                   // cycle 4: WB
    check("addi_wb_pcwe", {63'd0, pc_we_o}, 64'd1);
    check("addi_wb_rfwe", {63'd0, rf_we_o}, 64'd1);
    pc_i = 64'h8000_0008;
    tick();
    check("addi_after_pcwe", {63'd0, pc_we_o}, 64'd0);
    check("addi_after_req",  {63'd0, mem_req_o}, 64'd1);
`ifdef YSYX_22040237_PERF_CNT_EN
    check("addi_instret", instret_o,   64'd1);
    check("addi_cycles",  cycle_cnt_o, 64'd5);
`endif

    // 2: fetch with 3-cycle grant stall and rvalid two cycles after grant.
    do_fetch(64'h8000_0008, 64'hFFFF_FFFF_0000_0033, 3, 1, 32'h0000_0033);
    tick();
    check("stall_wb_pcwe", {63'd0, pc_we_o}, 64'd1);
    pc_i = 64'h8000_0004;
    tick();
    check("stall_wb_single", {63'd0, pc_we_o}, 64'd0);

    // 3: upper word fetch, then a store.
    do_fetch(64'h8000_0004, 64'h00A3_0023_0000_0013, 0, 0, 32'h00A3_0023);
    dec_is_store_i = 1'b1; rd_wr_en_i = 1'b0;
    lsu_addr_i = 64'h8000_0100; lsu_wdata_i = 64'h1122_3344_5566_7788; lsu_wmask_i = 8'h0F;
    tick();                                   // MEM_REQ
    check("st_req",   {63'd0, mem_req_o}, 64'd1);
    check("st_we",    {63'd0, mem_we_o},  64'd1);
    check("st_addr",  mem_addr_o,  64'h8000_0100);
    check("st_wdata", mem_wdata_o, 64'h1122_3344_5566_7788);
    check("st_mask",  {56'd0, mem_wmask_o}, 64'h0F);
    mem_gnt_i = 1'b1;
    tick();                                   // MEM_WAIT
    mem_gnt_i = 1'b0;
    check("st_wait_noreq", {63'd0, mem_req_o}, 64'd0);
    mem_rvalid_i = 1'b1;
    tick();                                   // WB
    mem_rvalid_i = 1'b0;
    check("st_wb_pcwe", {63'd0, pc_we_o}, 64'd1);
    check("st_wb_rfwe", {63'd0, rf_we_o}, 64'd0);
    dec_is_store_i = 1'b0;
    pc_i = 64'h8000_0010;
    tick();

    // 4: load from 0x80001000.
    do_fetch(64'h8000_0010, 64'h0000_0000_0000_B083, 0, 0, 32'h0000_B083);
    dec_is_load_i = 1'b1; rd_wr_en_i = 1'b1;
    lsu_addr_i = 64'h8000_1000; lsu_wmask_i = 8'hFF;
    tick();                                   // MEM_REQ
    check("ld_req",  {63'd0, mem_req_o}, 64'd1);
    check("ld_we",   {63'd0, mem_we_o},  64'd0);
    check("ld_addr", mem_addr_o, 64'h8000_1000);
    check("ld_mask", {56'd0, mem_wmask_o}, 64'd0);
    mem_gnt_i = 1'b1;
    tick();                                   // MEM_WAIT
    mem_gnt_i = 1'b0;
    mem_rvalid_i = 1'b1; mem_rdata_i = 64'hDEAD_BEEF_CAFE_F00D;
    tick();                                   // WB
    mem_rvalid_i = 1'b0; mem_rdata_i = '0;
    check("ld_wb_data", lsu_rdata_o, 64'hDEAD_BEEF_CAFE_F00D);
    check("ld_wb_rfwe", {63'd0, rf_we_o}, 64'd1);
    check("ld_wb_pcwe", {63'd0, pc_we_o}, 64'd1);
    pc_i = 64'h8000_0018;
    tick();

    // 5: reset while waiting for a load response.
    do_fetch(64'h8000_0018, 64'h0000_0000_0000_B083, 0, 0, 32'h0000_B083);
    tick();                                   // MEM_REQ
    mem_gnt_i = 1'b1;
    tick();                                   // MEM_WAIT
    mem_gnt_i = 1'b0;
    rst = 1'b1;
    tick();                                   // IDLE
    check_reset_outputs("midrst");
    rst = 1'b0;
    dec_is_load_i = 1'b0;
    pc_i = 64'h8000_0020;
    tick();                                   // FETCH_REQ
    check("midrst_fetch_req",  {63'd0, mem_req_o}, 64'd1);
    check("midrst_fetch_we",   {63'd0, mem_we_o},  64'd0);
    check("midrst_fetch_addr", mem_addr_o, 64'h8000_0020);

    // 6: invalid plus ebreak in EXEC -> trapped HALT, then reset.
    do_fetch(64'h8000_0020, 64'h0000_0000_FFFF_FFFF, 0, 0, 32'hFFFF_FFFF);
    dec_invalid_i = 1'b1; dec_halt_i = 1'b1;
    tick();                                   // HALT
    mem_gnt_i = 1'b1; mem_rvalid_i = 1'b1; mem_rdata_i = 64'h1234_5678_9ABC_DEF0;
    for (int unsigned i = 0; i < 3; i++) begin
      check("halt_halted", {63'd0, halted_o},  64'd1);
      check("halt_trap",   {63'd0, trap_o},    64'd1);
      check("halt_noreq",  {63'd0, mem_req_o}, 64'd0);
      check("halt_nopcwe", {63'd0, pc_we_o},   64'd0);
      tick();
    end
    check("halt_inst_held", {32'd0, inst_o}, 64'hFFFF_FFFF);
`ifdef YSYX_22040237_PERF_CNT_EN
    check("halt_cycles",  cycle_cnt_o, 64'd4);
    check("halt_instret", instret_o,   64'd0);
`endif
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
    dec_invalid_i = 1'b0; dec_halt_i = 1'b0;
    rst = 1'b1;
    tick();
    check_reset_outputs("post_halt_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ysyx_22040237_mcyc_ctrl.md
# ysyx_22040237_mcyc_ctrl

Multi-cycle sequencer for the ysyx_22040237 core, and arbiter of its single shared memory port. It steps each instruction through fetch, execute, memory and writeback states. It gives the memory port to the IFU fetch or to the LSU access, and produces the strobes that gate PC update and register-file write. It sits beside the pc_reg/ifu/idu/exu/lsu/wbu/regs datapath and makes it multi-cycle with variable-latency memory.

## Interface
Parameters:
- ADDR_W, 64, memory address / PC width
- DATA_W, 64, memory data width

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  core clock
- rst  in  1  synchronous active-high reset
- pc_i  in  ADDR_W  current PC from pc_reg
- pc_we_o  out  1  PC advance strobe; pc_reg loads next/jump PC only when high
- mem_req_o  out  1  memory request valid
- mem_we_o  out  1  1 = write, 0 = read
- mem_addr_o  out  ADDR_W  request address
- mem_wdata_o  out  DATA_W  write data
- mem_wmask_o  out  8  byte write mask; 0 on reads
- mem_gnt_i  in  1  request accepted this cycle
- mem_rvalid_i  in  1  response valid: read data, or write ack
- mem_rdata_i  in  DATA_W  read data
- inst_o  out  32  latched instruction to idu
- dec_is_load_i, dec_is_store_i, dec_invalid_i, dec_halt_i  in  1 each  idu decode flags (halt = ebreak)
- rd_wr_en_i  in  1  idu writeback enable
- lsu_addr_i  in  ADDR_W  LSU address
- lsu_wdata_i  in  DATA_W  LSU write data
- lsu_wmask_i  in  8  LSU byte mask
- lsu_rdata_o  out  DATA_W  captured load data
- rf_we_o  out  1  regfile write strobe
- halted_o  out  1  core stopped
- trap_o  out  1  stop caused by an invalid instruction

## Operation
- States: IDLE, FETCH_REQ, FETCH_WAIT, EXEC, MEM_REQ, MEM_WAIT, WB, HALT. Outputs decode from registered state (Moore).
- **IDLE:** entered on reset; goes to FETCH_REQ on the next cycle.
- **FETCH_REQ:** mem_req_o=1, mem_we_o=0, mem_addr_o=pc_i, mem_wmask_o=0. Stays here until mem_gnt_i, then goes to FETCH_WAIT.
- **FETCH_WAIT:** on mem_rvalid_i, inst_q gets mem_rdata_i[31:0] if pc_i[2]=0, else [63:32]; then EXEC.
- **EXEC:** one cycle.
  - dec_invalid_i: HALT with trap set.
  - Otherwise dec_halt_i: HALT.
  - Otherwise load or store: MEM_REQ.
  - Otherwise: WB.
- **MEM_REQ:** mem_req_o=1, mem_we_o=dec_is_store_i, address/data/mask from lsu_*. On mem_gnt_i, goes to MEM_WAIT.
- **MEM_WAIT:** on mem_rvalid_i, goes to WB. A load captures lsu_rdata_q <= mem_rdata_i. A store treats rvalid as the write ack.
- **WB:** rf_we_o=rd_wr_en_i, pc_we_o=1, then FETCH_REQ.
- **HALT:** sticky until rst. halted_o=1, no requests.
- While mem_req_o=1, address, we, wdata and wmask stay stable until grant. The request is never withdrawn.
- mem_rvalid_i is ignored outside the WAIT states. The memory shares rst, so no stale responses exist after reset.
- inst_o holds inst_q from FETCH_WAIT capture until the next capture. Decode and exec inputs are assumed stable from EXEC through WB.

## Timing
- Reset values:
  - state=IDLE
  - inst_q=0x00000013 (nop)
  - lsu_rdata_q=0
  - all strobes (mem_req_o, pc_we_o, rf_we_o) 0
  - halted_o=0, trap_o=0
- Fastest instruction with zero-wait memory (grant in the request cycle, rvalid the following cycle):
  - ALU/branch: 4 cycles (FETCH_REQ, FETCH_WAIT, EXEC, WB).
  - Load/store: 6 cycles.
- rvalid never arrives in the same cycle as its grant. The earliest rvalid is one cycle after grant.
- pc_we_o and rf_we_o are single-cycle pulses, exactly one per retired instruction.
- rst mid-transaction: IDLE on the next edge; the in-flight request is dropped.
- dec_invalid_i and dec_halt_i both high: trap_o=1.

## Configuration
- YSYX_22040237_PERF_CNT_EN defined: adds ports cycle_cnt_o [63:0] and instret_o [63:0].
  - Both reset to 0.
  - cycle_cnt_o increments every cycle the state is not HALT.
  - instret_o increments on every WB cycle.
- Undefined: those ports and the counters do not exist. Control behaviour is identical either way.

## Structure
- Shared defines file: state encodings (3-bit), nop constant 0x00000013, ADDR_W/DATA_W defaults.
- One sub-module: ysyx_22040237_perf_cnt (the two counters), instantiated only under YSYX_22040237_PERF_CNT_EN.

## Test plan
- Zero-wait memory, addi at PC 0x80000000:
  - mem_req_o high with addr 0x80000000.
  - rf_we_o and pc_we_o pulse in cycle 4 after IDLE.
  - instret_o=1.
- Fetch with 3-cycle grant stall, then rvalid 2 cycles later:
  - mem_addr_o stays stable throughout.
  - Exactly one WB pulse.
- PC 0x80000004, mem_rdata_i=0x00A30023_00000013: inst_o=0x00A30023 (upper word selected), followed by a store request with mem_we_o=1 and mask from lsu_wmask_i.
- Load with lsu_addr_i=0x80001000, rdata 0xDEADBEEF_CAFEF00D: lsu_rdata_o carries that value in WB, rf_we_o=1.
- dec_invalid_i in EXEC: HALT, trap_o=1, halted_o=1, no further mem_req_o. Then rst resets to IDLE with all outputs back to reset values.
- rst asserted in MEM_WAIT: state is IDLE next cycle, and the next request is a fetch at pc_i.
